wb_arbiter2: RTL and testbench

- Two-initiator to one-target Wishbone B4 pipelined arbiter, directly upstream of the SRAM peripheral.
- Initiator 0 is the CPU bus bridge; initiator 1 is the SPI/MCU bridge. The target port connects to the SRAM controller.
- Grants ownership per bus cycle (wb_cycle held) with round-robin tie-break.
- Tracks outstanding strobes, absorbs acks from abandoned cycles, and signals a watchdog timeout via err.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_arb_tracker.sv | 70 +++++++
 rtl/wb_arbiter2.sv | 157 +++++++++++++++
 tb/tb_wb_arbiter2.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared state encoding and counter widths for the two-initiator Wishbone arbiter.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   localparam int OUTST_W = 2;
   localparam int WDOG_W  = 8;

   localparam logic [OUTST_W-1:0] OUTST_ZERO = 2'd0;
   localparam logic [OUTST_W-1:0] OUTST_ONE  = 2'd1;
   localparam logic [WDOG_W-1:0]  WDOG_ZERO  = 8'd0;
   localparam logic [WDOG_W-1:0]  WDOG_ONE   = 8'd1;

endpackage

// File: rtl/wb_arb_tracker.sv
// Outstanding-strobe counter and no-progress watchdog for the arbiter target port.
module wb_arb_tracker
   import wb_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 1,
   parameter int TIMEOUT_CYCLES  = 31
) (
   input  logic               wb_clock_i,
   input  logic               wb_reset_i,
   input  logic               accept,
   input  logic               ack,
   input  logic               active,
   input  logic               state_chg,
   output logic [OUTST_W-1:0] outstanding,
   output logic               full,
   output logic               empty,
   output logic               timeout
);

   localparam logic [OUTST_W-1:0] MAX_O    = OUTST_W'(MAX_OUTSTANDING);
   localparam logic [WDOG_W-1:0]  WDOG_LIM = WDOG_W'(TIMEOUT_CYCLES);

   logic [OUTST_W-1:0] outstanding_r, outstanding_nxt_s;
   logic [WDOG_W-1:0]  wdog_r, wdog_nxt_s;
   logic               counted_ack_s;

   assign outstanding   = outstanding_r;
   assign full          = (outstanding_r == MAX_O);
   assign empty         = (outstanding_r == OUTST_ZERO);
   assign counted_ack_s = ack & ~empty;
   // Any progress in the expiry clock beats the timeout.
   assign timeout = active & ~empty & (wdog_r == WDOG_LIM) & ~accept & ~counted_ack_s;

   // Next-state for the counter and watchdog.
   always_comb begin
      outstanding_nxt_s = outstanding_r;
      wdog_nxt_s        = wdog_r;
      if (timeout) begin
         outstanding_nxt_s = OUTST_ZERO;
         wdog_nxt_s        = WDOG_ZERO;
      end else begin
         if (accept && !counted_ack_s && !full) begin
            outstanding_nxt_s = outstanding_r + OUTST_ONE;
         end else if (counted_ack_s && !accept) begin
            outstanding_nxt_s = outstanding_r - OUTST_ONE;
         end else begin
            outstanding_nxt_s = outstanding_r;
         end
         if (accept || counted_ack_s || state_chg) begin
            wdog_nxt_s = WDOG_ZERO;
         end else if (active && !empty) begin
            wdog_nxt_s = wdog_r + WDOG_ONE;
         end else begin
            wdog_nxt_s = wdog_r;
         end
      end
   end

   // Counter and watchdog registers.
   always_ff @(posedge wb_clock_i or negedge wb_reset_i) begin
      if (!wb_reset_i) begin
         outstanding_r <= OUTST_ZERO;
         wdog_r        <= WDOG_ZERO;
      end else begin
         outstanding_r <= outstanding_nxt_s;
         wdog_r        <= wdog_nxt_s;
      end
   end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-initiator to one-target Wishbone B4 pipelined arbiter: per-cycle ownership,
// round-robin tie-break, ack absorption for abandoned cycles and a watchdog error.
module wb_arbiter2
   import wb_arb_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 17,
   parameter int MAX_OUTSTANDING = 1,
   parameter int TIMEOUT_CYCLES  = 31
) (
   input  logic                  wb_clock_i,
   input  logic                  wb_reset_i,
   input  logic [ADDR_WIDTH-1:0] i0_addr_i,
   input  logic [DATA_WIDTH-1:0] i0_data_i,
   output logic [DATA_WIDTH-1:0] i0_data_o,
   input  logic                  i0_we_i,
   input  logic                  i0_cycle_i,
   input  logic                  i0_strobe_i,
   output logic                  i0_stall_o,
   output logic                  i0_ack_o,
   output logic                  i0_err_o,
   input  logic [ADDR_WIDTH-1:0] i1_addr_i,
   input  logic [DATA_WIDTH-1:0] i1_data_i,
   output logic [DATA_WIDTH-1:0] i1_data_o,
   input  logic                  i1_we_i,
   input  logic                  i1_cycle_i,
   input  logic                  i1_strobe_i,
   output logic                  i1_stall_o,
   output logic                  i1_ack_o,
   output logic                  i1_err_o,
   output logic [ADDR_WIDTH-1:0] t_addr_o,
   output logic [DATA_WIDTH-1:0] t_data_o,
   input  logic [DATA_WIDTH-1:0] t_data_i,
   output logic                  t_we_o,
   output logic                  t_cycle_o,
   output logic                  t_strobe_o,
   input  logic                  t_stall_i,
   input  logic                  t_ack_i
);

   arb_state_t         state_r, state_nxt_s;
   logic               last_grant_r, last_grant_nxt_s;
   logic [OUTST_W-1:0] outstanding_s;
   logic               full_s, empty_s, timeout_s;
   logic               accept_s, counted_ack_s, active_s, state_chg_s, release_idle_s;

   assign accept_s      = t_strobe_o & ~t_stall_i;
   assign counted_ack_s = t_ack_i & ~empty_s;
   assign active_s      = (state_r != IDLE);
   assign state_chg_s   = (state_nxt_s != state_r);
   // True when nothing will be left in flight after this clock.
   assign release_idle_s = ~accept_s & (empty_s | (counted_ack_s & (outstanding_s == OUTST_ONE)));

   assign i0_data_o = t_data_i;
   assign i1_data_o = t_data_i;
   assign i0_err_o  = (state_r == OWN0) & timeout_s;
   assign i1_err_o  = (state_r == OWN1) & timeout_s;

   wb_arb_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
   ) u_tracker (
      .wb_clock_i  (wb_clock_i),
      .wb_reset_i  (wb_reset_i),
      .accept      (accept_s),
      .ack         (t_ack_i),
      .active      (active_s),
      .state_chg   (state_chg_s),
      .outstanding (outstanding_s),
      .full        (full_s),
      .empty       (empty_s),
      .timeout     (timeout_s)
   );

   // Ownership FSM and round-robin tie-break.
   always_comb begin
      state_nxt_s      = state_r;
      last_grant_nxt_s = last_grant_r;
      case (state_r)
         IDLE: begin
            if (i0_cycle_i && i1_cycle_i) begin
               state_nxt_s      = last_grant_r ? OWN0 : OWN1;
               last_grant_nxt_s = ~last_grant_r;
            end else if (i0_cycle_i) begin
               state_nxt_s      = OWN0;
               last_grant_nxt_s = 1'b0;
            end else if (i1_cycle_i) begin
               state_nxt_s      = OWN1;
               last_grant_nxt_s = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         OWN0: begin
            if (timeout_s)        state_nxt_s = IDLE;
            else if (!i0_cycle_i) state_nxt_s = release_idle_s ? IDLE : DRAIN;
            else                  state_nxt_s = OWN0;
         end
         OWN1: begin
            if (timeout_s)        state_nxt_s = IDLE;
            else if (!i1_cycle_i) state_nxt_s = release_idle_s ? IDLE : DRAIN;
            else                  state_nxt_s = OWN1;
         end
         DRAIN: begin
            if (timeout_s || release_idle_s) state_nxt_s = IDLE;
            else                             state_nxt_s = DRAIN;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State and last-grant registers; i0 wins the first tie after reset.
   always_ff @(posedge wb_clock_i or negedge wb_reset_i) begin
      if (!wb_reset_i) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
      end else begin
         state_r      <= state_nxt_s;
         last_grant_r <= last_grant_nxt_s;
      end
   end

   // Route the owner to the target; everyone else is stalled and silent.
   always_comb begin
      t_cycle_o  = 1'b0;
      t_strobe_o = 1'b0;
      t_we_o     = 1'b0;
      t_addr_o   = {ADDR_WIDTH{1'b0}};
      t_data_o   = {DATA_WIDTH{1'b0}};
      i0_stall_o = 1'b1;
      i0_ack_o   = 1'b0;
      i1_stall_o = 1'b1;
      i1_ack_o   = 1'b0;
      case (state_r)
         OWN0: begin
            t_cycle_o  = i0_cycle_i;
            t_strobe_o = i0_strobe_i & ~full_s;
            t_we_o     = i0_we_i;
            t_addr_o   = i0_addr_i;
            t_data_o   = i0_data_i;
            i0_stall_o = t_stall_i | full_s;
            i0_ack_o   = counted_ack_s;
         end
         OWN1: begin
            t_cycle_o  = i1_cycle_i;
            t_strobe_o = i1_strobe_i & ~full_s;
            t_we_o     = i1_we_i;
            t_addr_o   = i1_addr_i;
            t_data_o   = i1_data_i;
            i1_stall_o = t_stall_i | full_s;
            i1_ack_o   = counted_ack_s;
         end
         default: t_cycle_o = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed, table-driven bench for wb_arbiter2 with hand-written multi-cycle sequences.
module tb_wb_arbiter2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [16:0] i0_addr, i1_addr, t_addr;
   logic [7:0]  i0_wdat, i1_wdat, i0_rdat, i1_rdat, t_wdat, t_rdat;
   logic        i0_we, i0_cyc, i0_stb, i0_stall, i0_ack, i0_err;
   logic        i1_we, i1_cyc, i1_stb, i1_stall, i1_ack, i1_err;
   logic        t_we, t_cyc, t_stb, t_stall, t_ack;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   wb_arbiter2 dut (
      .wb_clock_i (clk),     .wb_reset_i (rst_n),
      .i0_addr_i  (i0_addr), .i0_data_i  (i0_wdat), .i0_data_o (i0_rdat),
      .i0_we_i    (i0_we),   .i0_cycle_i (i0_cyc),  .i0_strobe_i (i0_stb),
      .i0_stall_o (i0_stall), .i0_ack_o  (i0_ack),  .i0_err_o  (i0_err),
      .i1_addr_i  (i1_addr), .i1_data_i  (i1_wdat), .i1_data_o (i1_rdat),
      .i1_we_i    (i1_we),   .i1_cycle_i (i1_cyc),  .i1_strobe_i (i1_stb),
      .i1_stall_o (i1_stall), .i1_ack_o  (i1_ack),  .i1_err_o  (i1_err),
      .t_addr_o   (t_addr),  .t_data_o   (t_wdat),  .t_data_i  (t_rdat),
      .t_we_o     (t_we),    .t_cycle_o  (t_cyc),   .t_strobe_o (t_stb),
      .t_stall_i  (t_stall), .t_ack_i    (t_ack)
   );

   typedef struct {
      logic [2:0]  m0;   // {cycle, strobe, we}
      logic [16:0] a0;
      logic [7:0]  d0;
      logic [2:0]  m1;
      logic [16:0] a1;
      logic [7:0]  d1;
      logic [1:0]  ts;   // {t_stall, t_ack}
      logic [7:0]  tdat;
      logic [33:0] exp;  // {t_cyc,t_stb,t_we, t_addr, t_wdat, i0 stall/ack/err, i1 stall/ack/err}
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [2:0] m0, input logic [16:0] a0, input logic [7:0] d0,
                      input logic [2:0] m1, input logic [16:0] a1, input logic [7:0] d1,
                      input logic [1:0] ts, input logic [7:0] tdat,
                      input logic [2:0] tm, input logic [16:0] ta, input logic [7:0] td,
                      input logic [2:0] r0, input logic [2:0] r1);
      vec_t v;
      v.m0 = m0; v.a0 = a0; v.d0 = d0;
      v.m1 = m1; v.a1 = a1; v.d1 = d1;
      v.ts = ts; v.tdat = tdat;
      v.exp = {tm, ta, td, r0, r1};
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [49:0] observe();
      return {t_cyc, t_stb, t_we, t_addr, t_wdat, i0_stall, i0_ack, i0_err,
              i1_stall, i1_ack, i1_err, i0_rdat, i1_rdat};
   endfunction

   task automatic clr();
      {i0_cyc, i0_stb, i0_we} = 3'b000; i0_addr = 17'h00000; i0_wdat = 8'h00;
      {i1_cyc, i1_stb, i1_we} = 3'b000; i1_addr = 17'h00000; i1_wdat = 8'h00;
      {t_stall, t_ack} = 2'b00; t_rdat = 8'h00;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [33:0] IDLE_EXP = {3'b000, 17'h00000, 8'h00, 3'b100, 3'b100};

   int first_err;
   int err_cnt;

   initial begin
      clr();
      rst_n = 1'b0;
      #12;
      chk("reset_outputs", 64'(observe()), 64'({IDLE_EXP, 8'h00, 8'h00}));
      #11;
      rst_n = 1'b1;

      // Tie from reset goes to i0, then i1, then i0 again; spurious acks dropped.
      add(3'b100, 17'h00100, 8'h00, 3'b100, 17'h00200, 8'h00, 2'b00, 8'h00, 3'b000, 17'h00000, 8'h00, 3'b100, 3'b100);
      add(3'b100, 17'h00100, 8'h00, 3'b100, 17'h00200, 8'h00, 2'b01, 8'h5A, 3'b100, 17'h00100, 8'h00, 3'b000, 3'b100);
      add(3'b000, 17'h00100, 8'h00, 3'b100, 17'h00200, 8'h00, 2'b00, 8'h00, 3'b000, 17'h00100, 8'h00, 3'b000, 3'b100);
      add(3'b000, 17'h00100, 8'h00, 3'b100, 17'h00200, 8'h00, 2'b00, 8'h00, 3'b000, 17'h00000, 8'h00, 3'b100, 3'b100);
      add(3'b100, 17'h00100, 8'h00, 3'b100, 17'h00200, 8'h00, 2'b00, 8'h00, 3'b100, 17'h00200, 8'h00, 3'b100, 3'b000);
      add(3'b100, 17'h00100, 8'h00, 3'b000, 17'h00200, 8'h00, 2'b00, 8'h00, 3'b000, 17'h00200, 8'h00, 3'b100, 3'b000);
      add(3'b100, 17'h00100, 8'h00, 3'b100, 17'h00200, 8'h00, 2'b00, 8'h00, 3'b000, 17'h00000, 8'h00, 3'b100, 3'b100);
      add(3'b100, 17'h00100, 8'h00, 3'b100, 17'h00200, 8'h00, 2'b00, 8'h00, 3'b100, 17'h00100, 8'h00, 3'b000, 3'b100);
      add(3'b000, 17'h00100, 8'h00, 3'b000, 17'h00200, 8'h00, 2'b00, 8'h00, 3'b000, 17'h00100, 8'h00, 3'b000, 3'b100);
      add(3'b000, 17'h00000, 8'h00, 3'b000, 17'h00000, 8'h00, 2'b01, 8'h00, 3'b000, 17'h00000, 8'h00, 3'b100, 3'b100);
      // Single read by i0, ack 7 clocks after accept.
      add(3'b110, 17'h1F000, 8'h00, 3'b000, 17'h00000, 8'h00, 2'b00, 8'h00, 3'b000, 17'h00000, 8'h00, 3'b100, 3'b100);
      add(3'b110, 17'h1F000, 8'h00, 3'b000, 17'h00000, 8'h00, 2'b00, 8'h00, 3'b110, 17'h1F000, 8'h00, 3'b000, 3'b100);
      for (int k = 0; k < 6; k++)
         add(3'b100, 17'h1F000, 8'h00, 3'b000, 17'h00000, 8'h00, 2'b00, 8'h00, 3'b100, 17'h1F000, 8'h00, 3'b100, 3'b100);
      add(3'b100, 17'h1F000, 8'h00, 3'b000, 17'h00000, 8'h00, 2'b01, 8'hA5, 3'b100, 17'h1F000, 8'h00, 3'b110, 3'b100);
      add(3'b100, 17'h1F000, 8'h00, 3'b000, 17'h00000, 8'h00, 2'b00, 8'h00, 3'b100, 17'h1F000, 8'h00, 3'b000, 3'b100);
      add(3'b000, 17'h1F000, 8'h00, 3'b000, 17'h00000, 8'h00, 2'b00, 8'h00, 3'b000, 17'h1F000, 8'h00, 3'b000, 3'b100);
      add(3'b000, 17'h00000, 8'h00, 3'b000, 17'h00000, 8'h00, 2'b00, 8'h00, 3'b000, 17'h00000, 8'h00, 3'b100, 3'b100);
      // Back-pressure: two i1 writes, target stalls 3 clocks, strobe masked while full.
      add(3'b000, 17'h00000, 8'h00, 3'b111, 17'h00010, 8'h11, 2'b00, 8'h00, 3'b000, 17'h00000, 8'h00, 3'b100, 3'b100);
      for (int k = 0; k < 3; k++)
         add(3'b000, 17'h00000, 8'h00, 3'b111, 17'h00010, 8'h11, 2'b10, 8'h00, 3'b111, 17'h00010, 8'h11, 3'b100, 3'b100);
      add(3'b000, 17'h00000, 8'h00, 3'b111, 17'h00010, 8'h11, 2'b00, 8'h00, 3'b111, 17'h00010, 8'h11, 3'b100, 3'b000);
      add(3'b000, 17'h00000, 8'h00, 3'b111, 17'h00011, 8'h22, 2'b00, 8'h00, 3'b101, 17'h00011, 8'h22, 3'b100, 3'b100);
      add(3'b000, 17'h00000, 8'h00, 3'b111, 17'h00011, 8'h22, 2'b01, 8'h00, 3'b101, 17'h00011, 8'h22, 3'b100, 3'b110);
      add(3'b000, 17'h00000, 8'h00, 3'b111, 17'h00011, 8'h22, 2'b00, 8'h00, 3'b111, 17'h00011, 8'h22, 3'b100, 3'b000);
      add(3'b000, 17'h00000, 8'h00, 3'b101, 17'h00011, 8'h22, 2'b01, 8'h00, 3'b101, 17'h00011, 8'h22, 3'b100, 3'b110);
      add(3'b000, 17'h00000, 8'h00, 3'b000, 17'h00011, 8'h22, 2'b00, 8'h00, 3'b000, 17'h00011, 8'h22, 3'b100, 3'b000);
      add(3'b000, 17'h00000, 8'h00, 3'b000, 17'h00000, 8'h00, 2'b00, 8'h00, 3'b000, 17'h00000, 8'h00, 3'b100, 3'b100);

      for (int i = 0; i < vq.size(); i++) begin
         tick();
         {i0_cyc, i0_stb, i0_we} = vq[i].m0; i0_addr = vq[i].a0; i0_wdat = vq[i].d0;
         {i1_cyc, i1_stb, i1_we} = vq[i].m1; i1_addr = vq[i].a1; i1_wdat = vq[i].d1;
         {t_stall, t_ack} = vq[i].ts; t_rdat = vq[i].tdat;
         @(negedge clk);
         chk($sformatf("vec%0d", i), 64'(observe()), 64'({vq[i].exp, vq[i].tdat, vq[i].tdat}));
      end

      // Abandon: i0 drops cycle one clock after accept; ack absorbed, i1 waits for it.
      tick(); clr(); i0_cyc = 1'b1; i0_stb = 1'b1; i0_addr = 17'h00AAA;
      tick();
      @(negedge clk); chk("abandon_accept", 64'(t_stb), 64'd1);
      tick(); i0_cyc = 1'b0; i0_stb = 1'b0; i1_cyc = 1'b1; i1_addr = 17'h00BBB;
      @(negedge clk); chk("abandon_release", 64'({t_cyc, i1_stall}), 64'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge clk); chk("drain_hold", 64'({t_cyc, i1_stall, i0_ack}), 64'd2);
      end
      tick(); t_ack = 1'b1;
      @(negedge clk); chk("drain_absorb", 64'({t_cyc, i0_ack, i1_ack}), 64'd0);
      tick(); t_ack = 1'b0;
      @(negedge clk); chk("drain_to_idle", 64'({t_cyc, i1_stall}), 64'd1);
      tick();
      @(negedge clk); chk("abandon_i1_grant", 64'({t_cyc, i1_stall, t_addr}), 64'({2'b10, 17'h00BBB}));
      tick(); i1_cyc = 1'b0;
      tick();

      // Timeout: target never acks; err after 31 clocks of no progress, once.
      clr(); i0_cyc = 1'b1; i0_stb = 1'b1; i0_addr = 17'h00CCC;
      tick();
      @(negedge clk); chk("timeout_accept", 64'(t_stb), 64'd1);
      first_err = -1;
      err_cnt = 0;
      for (int n = 0; n < 36; n++) begin
         tick();
         if (first_err >= 0) i0_cyc = 1'b0;
         else                i0_stb = 1'b0;
         @(negedge clk);
         if (i0_err) begin
            err_cnt++;
            if (first_err < 0) first_err = n;
         end
         if (first_err >= 0 && n == first_err + 1)
            chk("timeout_idle", 64'({t_cyc, i0_stall}), 64'd1);
      end
      chk("timeout_latency", 64'(first_err), 64'd31);
      chk("timeout_pulses", 64'(err_cnt), 64'd1);
      tick(); t_ack = 1'b1;
      @(negedge clk); chk("late_ack_dropped", 64'({i0_ack, i1_ack}), 64'd0);
      tick(); t_ack = 1'b0;

      // Asynchronous reset in the middle of an i1 write.
      clr(); i1_cyc = 1'b1; i1_stb = 1'b1; i1_we = 1'b1; i1_addr = 17'h00020; i1_wdat = 8'h33; t_stall = 1'b1;
      tick();
      @(negedge clk); chk("rst_pre_own1", 64'({t_cyc, i1_stall}), 64'd3);
      #2;
      rst_n = 1'b0; t_ack = 1'b1;
      #1;
      chk("rst_async", 64'({t_cyc, t_stb, i1_stall, i1_ack, i1_err}), 64'd4);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      clr(); i0_cyc = 1'b1; i1_cyc = 1'b1; i0_addr = 17'h00040; i1_addr = 17'h00050;
      tick();
      @(negedge clk); chk("rst_tie_i0", 64'({t_cyc, i0_stall, i1_stall, t_addr}), 64'({3'b101, 17'h00040}));
      tick(); clr();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
